metadata_fetch_scheduler: RTL and testbench

- Shares one single-port note-metadata BRAM among the 37 per-lane requesters driven by the score/chart block.
- Round-robin arbitrates the `metadata_request` bits and reads the next 16-bit word for the granted channel into that channel's slot of `metadata_link`.
- Keeps a per-channel read pointer and pulses a one-hot ack when a slot is refreshed.
- Sits between the control/loader block (which owns pause and song restart) and the metadata BRAM.

---
 rtl/ghffe_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/metadata_fetch_scheduler.sv | 120 ++++++++++++
 tb/tb_metadata_fetch_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ghffe_pkg.sv
// Shared constants and FSM state type for the note-metadata fetch scheduler.
package ghffe_pkg;

  localparam int unsigned N_REQ    = 37;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned CH_W     = 6;
  localparam int unsigned PTR_W    = 8;
  localparam int unsigned CH_DEPTH = 2 ** PTR_W;
  localparam int unsigned ADDR_W   = CH_W + PTR_W;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite
  } fsm_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select: first set request at or after last+1, with wrap.
module rr_arbiter
  import ghffe_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [CH_W-1:0]  last_i,
  input  logic             enable_i,
  output logic [CH_W-1:0]  winner_o,
  output logic             valid_o
);

  logic [CH_W:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    if (enable_i) begin
      // Offsets 1..N_REQ so the last winner is considered only after everyone else.
      for (int k = 1; k <= int'(N_REQ); k++) begin
        idx = {1'b0, last_i} + (CH_W + 1)'(k);
        if (idx >= (CH_W + 1)'(N_REQ)) begin
          idx = idx - (CH_W + 1)'(N_REQ);
        end
        if (!valid_o && req_i[idx[CH_W-1:0]]) begin
          winner_o = idx[CH_W-1:0];
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/metadata_fetch_scheduler.sv
// Shares one single-port metadata BRAM among N_REQ lane requesters, one read in flight at a time.
module metadata_fetch_scheduler
  import ghffe_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pause,
  input  logic                      rewind,
  input  logic [N_REQ-1:0]          metadata_request,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [WORD_W-1:0]         mem_dout,
  output logic [N_REQ*WORD_W-1:0]   metadata_link,
  output logic [N_REQ-1:0]          metadata_ack,
  output logic [CH_W-1:0]           grant_idx,
  output logic                      busy
);

  localparam int unsigned WaitLast = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  fsm_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [PTR_W-1:0]  ptr_q  [N_REQ];
  logic [WORD_W-1:0] slot_q [N_REQ];

  logic              arb_valid;
  logic [CH_W-1:0]   arb_winner;

  // Pause is only honoured here: once a grant is taken the transaction always completes.
  rr_arbiter u_rr_arbiter (
    .req_i    (metadata_request),
    .last_i   (last_q),
    .enable_i (!pause && (state_q == StIdle)),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          last_d  = arb_winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = (RD_LAT > 1) ? StWait : StWrite;
      end
      StWait: begin
        if (wait_cnt_q == 3'(WaitLast)) begin
          state_d = StWrite;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_q     <= CH_W'(N_REQ - 1);
      wait_cnt_q <= '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        ptr_q[i]  <= '0;
        slot_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      for (int i = 0; i < int'(N_REQ); i++) begin
        // Rewind wins over the post-write increment, so a rewound channel restarts at 0.
        if (rewind) begin
          ptr_q[i] <= '0;
        end else if (state_q == StWrite && grant_q == CH_W'(i)) begin
          ptr_q[i] <= (ptr_q[i] == PTR_W'(CH_DEPTH - 1)) ? '0 : ptr_q[i] + 1'b1;
        end
        if (state_q == StWrite && grant_q == CH_W'(i)) begin
          slot_q[i] <= mem_dout;
        end
      end
    end
  end

  always_comb begin
    metadata_ack = '0;
    if (state_q == StWrite) begin
      metadata_ack[grant_q] = 1'b1;
    end
  end

  assign mem_en    = (state_q == StIssue);
  assign mem_addr  = {grant_q, ptr_q[grant_q]};
  assign grant_idx = grant_q;
  assign busy      = (state_q != StIdle);

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_link
    assign metadata_link[i*WORD_W +: WORD_W] = slot_q[i];
  end

endmodule

// File: tb/tb_metadata_fetch_scheduler.sv
// Scoreboard bench: stimulus queues expected reads/acks, a negedge monitor pops and compares.
module tb_metadata_fetch_scheduler;
  import ghffe_pkg::*;

  localparam int RD_LAT = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    pause = 1'b0;
  logic                    rewind = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [WORD_W-1:0]       mem_dout;
  logic [N_REQ*WORD_W-1:0] metadata_link;
  logic [N_REQ-1:0]        metadata_ack;
  logic [CH_W-1:0]         grant_idx;
  logic                    busy;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;

  logic [ADDR_W-1:0] exp_addr [$];
  int                exp_ch   [$];
  logic [WORD_W-1:0] exp_data [$];

  metadata_fetch_scheduler #(
    .RD_LAT (RD_LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pause            (pause),
    .rewind           (rewind),
    .metadata_request (req),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .mem_dout         (mem_dout),
    .metadata_link    (metadata_link),
    .metadata_ack     (metadata_ack),
    .grant_idx        (grant_idx),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // BRAM contents: address 0 holds A5A5, every other word is its address XOR 3C3C.
  function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == '0) return 16'hA5A5;
    return {2'b00, a} ^ 16'h3C3C;
  endfunction

  logic [WORD_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? mem_word(mem_addr) : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_addr(input int ch, input int ptr);
    exp_addr.push_back({6'(ch), 8'(ptr)});
  endtask

  task automatic expect_txn(input int ch, input int ptr);
    logic [ADDR_W-1:0] a;
    a = {6'(ch), 8'(ptr)};
    exp_addr.push_back(a);
    exp_ch.push_back(ch);
    exp_data.push_back(mem_word(a));
  endtask

  task automatic wait_acks(input int n, input string name);
    int target;
    int cyc;
    target = ack_cnt + n;
    cyc = 0;
    while (ack_cnt < target && cyc < n * 20 + 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (ack_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, saw %0d acks, expected %0d", name, ack_cnt, target);
    end
  endtask

  task automatic wait_mem_en(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!mem_en && cyc < 50);
    if (!mem_en) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout waiting for mem_en, got 0 expected 1", name);
    end
  endtask

  // Monitor: every mem_en and every ack must match the head of its queue.
  initial begin
    logic              slot_pending;
    int                slot_ch;
    logic [WORD_W-1:0] slot_data;
    logic [N_REQ-1:0]  ack_exp;
    slot_pending = 1'b0;
    slot_ch = 0;
    slot_data = '0;
    forever begin
      @(negedge clk);
      if (slot_pending) begin
        chk("slot_value", 64'(metadata_link[slot_ch*WORD_W +: WORD_W]), 64'(slot_data));
        slot_pending = 1'b0;
      end
      if (mem_en) begin
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_mem_en: got addr %0h, expected no read", mem_addr);
        end else begin
          chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
        end
      end
      if (metadata_ack != '0) begin
        ack_cnt++;
        if (exp_ch.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: got %0h, expected no ack", metadata_ack);
        end else begin
          slot_ch   = exp_ch.pop_front();
          slot_data = exp_data.pop_front();
          ack_exp   = '0;
          ack_exp[slot_ch] = 1'b1;
          chk("ack_onehot", 64'(metadata_ack), 64'(ack_exp));
          slot_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_grant", 64'(grant_idx), 0);
    chk("rst_ack", 64'(metadata_ack), 0);
    chk("rst_link_zero", 64'(metadata_link == '0), 1);

    // Single request on channel 0, latency checked cycle by cycle.
    expect_txn(0, 0);
    req[0] = 1'b1;
    @(negedge clk); #1;
    chk("t1_issue_mem_en", 64'(mem_en), 1);
    chk("t1_issue_addr", 64'(mem_addr), 0);
    chk("t1_issue_busy", 64'(busy), 1);
    @(negedge clk); #1;
    chk("t1_wait_mem_en", 64'(mem_en), 0);
    chk("t1_wait_ack", 64'(metadata_ack), 0);
    @(negedge clk); #1;
    chk("t1_write_ack", 64'(metadata_ack), 1);
    req[0] = 1'b0;
    @(negedge clk); #1;
    chk("t1_slot0", 64'(metadata_link[15:0]), 64'h A5A5);
    chk("t1_idle_busy", 64'(busy), 0);
    expect_txn(0, 1);
    req[0] = 1'b1;
    wait_acks(1, "t1_second");
    req[0] = 1'b0;

    // Three held requests rotate fairly.
    expect_txn(3, 0);  expect_txn(10, 0); expect_txn(36, 0);
    expect_txn(3, 1);  expect_txn(10, 1); expect_txn(36, 1);
    req[3] = 1'b1; req[10] = 1'b1; req[36] = 1'b1;
    wait_acks(6, "t2_rr");
    req = '0;

    // Channel 5 pointer walks the full depth and wraps.
    for (int p = 0; p < 257; p++) expect_txn(5, p % 256);
    req[5] = 1'b1;
    wait_acks(257, "t3_wrap");
    req[5] = 1'b0;

    // Pause raised during WAIT of channel 2.
    expect_txn(2, 0);
    expect_txn(4, 0);
    req[2] = 1'b1; req[4] = 1'b1;
    wait_mem_en("t4_issue");
    @(negedge clk); #1;
    pause = 1'b1;
    wait_acks(1, "t4_ack_ch2");
    req[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      chk("t4_paused_mem_en", 64'(mem_en), 0);
    end
    pause = 1'b0;
    @(negedge clk); #1;
    chk("t4_resume_mem_en", 64'(mem_en), 1);
    chk("t4_resume_grant", 64'(grant_idx), 4);
    wait_acks(1, "t4_ack_ch4");
    req[4] = 1'b0;

    // Rewind in the WRITE cycle of channel 7 at ptr 9.
    for (int p = 0; p < 10; p++) expect_txn(7, p);
    expect_txn(7, 0);
    req[7] = 1'b1;
    wait_acks(10, "t5_fill");
    chk("t5_write_ack", 64'(metadata_ack[7]), 1);
    rewind = 1'b1;
    @(negedge clk); #1;
    rewind = 1'b0;
    wait_acks(1, "t5_after_rewind");
    req[7] = 1'b0;

    // Reset during WAIT aborts the read without an ack.
    expect_addr(10, 0);
    req[10] = 1'b1;
    wait_mem_en("t6_issue");
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk("t6_busy", 64'(busy), 0);
    chk("t6_ack", 64'(metadata_ack), 0);
    chk("t6_link_zero", 64'(metadata_link == '0), 1);
    reset = 1'b0;
    expect_txn(10, 0);
    wait_acks(1, "t6_after_reset");
    req[10] = 1'b0;

    repeat (6) @(negedge clk);
    #1;
    chk("left_addr", 64'(exp_addr.size()), 0);
    chk("left_acks", 64'(exp_ch.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
